// File: rtl/gba_timer_bank_pkg.sv
// Shared constants and helpers for the GBA timer bank: control bit positions,
// prescale masks, register offsets and width decode.
package gba_timer_bank_pkg;

  localparam int unsigned CTL_START = 7;
  localparam int unsigned CTL_IRQ   = 6;
  localparam int unsigned CTL_CUP   = 2;

  // Writable control bits; everything else reads back as 0.
  localparam logic [7:0] CTL_RW_MASK  = 8'hC7;
  localparam logic [7:0] CTL_CUP_BIT  = 8'h04;

  localparam logic [9:0] PS_MASK_1    = 10'd0;
  localparam logic [9:0] PS_MASK_64   = 10'd63;
  localparam logic [9:0] PS_MASK_256  = 10'd255;
  localparam logic [9:0] PS_MASK_1024 = 10'd1023;

  localparam int unsigned OFF_RELOAD = 0;
  localparam int unsigned OFF_CTL    = 2;

  typedef enum logic [1:0] {
    PsDiv1    = 2'b00,
    PsDiv64   = 2'b01,
    PsDiv256  = 2'b10,
    PsDiv1024 = 2'b11
  } prescale_e;

  function automatic logic [9:0] ps_mask(input logic [1:0] ps);
    logic [9:0] m;
    m = PS_MASK_1;
    unique case (prescale_e'(ps))
      PsDiv1:    m = PS_MASK_1;
      PsDiv64:   m = PS_MASK_64;
      PsDiv256:  m = PS_MASK_256;
      PsDiv1024: m = PS_MASK_1024;
      default:   m = PS_MASK_1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] width_be(input logic [1:0] w);
    logic [3:0] be;
    case (w)
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/gba_timer_bank_channel.sv
// One timer channel: reload, control, prescale counter and live counter,
// with cascade input and overflow/IRQ pulse outputs.
module gba_timer_bank_channel
  import gba_timer_bank_pkg::*;
#(
  parameter bit IsFirst = 1'b0
) (
  input  logic        i_clk_mem,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_cascade_in,
  input  logic        i_we,
  input  logic [2:0]  i_be,
  input  logic [23:0] i_wdata,
  output logic [15:0] o_counter,
  output logic [7:0]  o_control,
  output logic        o_ovf,
  output logic        o_irq
);

  // Channel 0 has no predecessor, so its count-up bit is never stored.
  localparam logic [7:0] CtlMask = IsFirst ? (CTL_RW_MASK & ~CTL_CUP_BIT) : CTL_RW_MASK;

  logic [15:0] r_counter;
  logic [15:0] r_reload;
  logic [7:0]  r_ctl;
  logic [9:0]  r_pcount;

  logic [15:0] w_new_reload;
  logic [7:0]  w_new_ctl;
  logic [9:0]  w_mask;
  logic        w_ctl_we;
  logic        w_start_edge;
  logic        w_running;
  logic        w_cup;
  logic        w_pre_hit;
  logic        w_step;
  logic        w_wrap;

  always_comb begin
    w_new_reload = r_reload;
    if (i_we && i_be[0]) w_new_reload[7:0]  = i_wdata[7:0];
    if (i_we && i_be[1]) w_new_reload[15:8] = i_wdata[15:8];
  end

  assign w_ctl_we     = i_we & i_be[2];
  assign w_new_ctl    = w_ctl_we ? (i_wdata[23:16] & CtlMask) : r_ctl;
  assign w_start_edge = w_ctl_we & w_new_ctl[CTL_START] & ~r_ctl[CTL_START];

  // The step is always evaluated against the control held before this cycle's write.
  assign w_running = r_ctl[CTL_START];
  assign w_cup     = r_ctl[CTL_CUP];
  assign w_mask    = ps_mask(r_ctl[1:0]);
  assign w_pre_hit = (r_pcount & w_mask) == w_mask;
  assign w_step    = w_running & (w_cup ? i_cascade_in : (i_tick & w_pre_hit));
  assign w_wrap    = w_step & (r_counter == 16'hFFFF);

  always_ff @(posedge i_clk_mem or posedge i_rst) begin
    if (i_rst) begin
      r_counter <= 16'h0000;
      r_reload  <= 16'h0000;
      r_ctl     <= 8'h00;
      r_pcount  <= 10'd0;
    end else begin
      r_reload <= w_new_reload;
      r_ctl    <= w_new_ctl;
      if (w_start_edge) begin
        r_counter <= w_new_reload;
        r_pcount  <= 10'd0;
      end else begin
        if (w_wrap) begin
          r_counter <= r_reload;
        end else if (w_step) begin
          r_counter <= r_counter + 16'd1;
        end
        if (w_running && !w_cup && i_tick) begin
          r_pcount <= r_pcount + 10'd1;
        end
      end
    end
  end

  assign o_counter = r_counter;
  assign o_control = r_ctl;
  assign o_ovf     = w_wrap;
  assign o_irq     = w_wrap & r_ctl[CTL_IRQ];

endmodule

// File: rtl/gba_timer_bank.sv
// GBA timer bank top: tick divider, io-window decode, write-lane alignment,
// read mux and the cascaded channel array.
module gba_timer_bank
  import gba_timer_bank_pkg::*;
#(
  parameter int unsigned N_TIMERS  = 4,
  parameter logic [11:0] BASE_ADDR = 12'h100,
  parameter int unsigned TICK_DIV  = 3
) (
  input  logic                i_clk_mem,
  input  logic                i_rst,
  input  logic [11:0]         i_addr,
  input  logic [31:0]         i_data_in,
  output logic [31:0]         o_data_out,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [1:0]          i_width,
  output logic [N_TIMERS-1:0] o_irq,
  output logic [N_TIMERS-1:0] o_ovf
);

  localparam int unsigned DivW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam logic [12:0] WinEnd  = 13'(BASE_ADDR) + 13'(4 * N_TIMERS);

  logic [DivW-1:0] r_div;
  logic            w_tick;

  logic            w_in_win;
  logic [2:0]      w_sel;
  logic [1:0]      w_byte;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_word;
  logic            w_unused_bits;

  logic [15:0]     w_counter [N_TIMERS];
  logic [7:0]      w_ctl     [N_TIMERS];

  assign w_tick = (r_div == DivLast);

  always_ff @(posedge i_clk_mem or posedge i_rst) begin
    if (i_rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_in_win = (i_addr >= BASE_ADDR) && ({1'b0, i_addr} < WinEnd);
  assign w_sel    = 3'((i_addr - BASE_ADDR) >> 2);
  assign w_byte   = i_addr[1:0];
  assign w_be     = 4'(width_be(i_width) << w_byte);
  assign w_wdata  = i_data_in << {w_byte, 3'b000};

  // The top byte carries no control bits and reads are side-effect free.
  assign w_unused_bits = ^{w_wdata[31:24], w_be[3], i_read};

  for (genvar i = 0; i < N_TIMERS; i++) begin : g_ch
    logic w_cas;
    logic w_ovf_ch;
    logic w_irq_ch;
    logic w_we;

    if (i == 0) begin : g_first
      assign w_cas = 1'b0;
    end else begin : g_chain
      assign w_cas = g_ch[i-1].w_ovf_ch;
    end

    assign w_we = i_write & w_in_win & (w_sel == 3'(i));

    gba_timer_bank_channel #(
      .IsFirst (i == 0)
    ) u_channel (
      .i_clk_mem    (i_clk_mem),
      .i_rst        (i_rst),
      .i_tick       (w_tick),
      .i_cascade_in (w_cas),
      .i_we         (w_we),
      .i_be         (w_be[2:0]),
      .i_wdata      (w_wdata[23:0]),
      .o_counter    (w_counter[i]),
      .o_control    (w_ctl[i]),
      .o_ovf        (w_ovf_ch),
      .o_irq        (w_irq_ch)
    );

    assign o_ovf[i] = w_ovf_ch;
    assign o_irq[i] = w_irq_ch;
  end

  always_comb begin
    w_word = 32'h0000_0000;
    for (int i = 0; i < N_TIMERS; i++) begin
      if (w_in_win && (w_sel == 3'(i))) begin
        w_word = {8'h00, w_ctl[i], w_counter[i]};
      end
    end
  end

  assign o_data_out = w_word >> {w_byte, 3'b000};

endmodule

// File: tb/tb_gba_timer_bank.sv
// Self-checking bench for gba_timer_bank against a cycle-level behavioural model.
module tb_gba_timer_bank;

  localparam int N          = 4;
  localparam int BASE       = 12'h100;
  localparam int TD         = 3;
  localparam int EW         = 2 * N + 32;

  logic          clk;
  logic          i_rst;
  logic [11:0]   i_addr;
  logic [31:0]   i_data_in;
  logic [31:0]   o_data_out;
  logic          i_read;
  logic          i_write;
  logic [1:0]    i_width;
  logic [N-1:0]  o_irq;
  logic [N-1:0]  o_ovf;

  gba_timer_bank #(
    .N_TIMERS  (N),
    .BASE_ADDR (12'h100),
    .TICK_DIV  (TD)
  ) dut (
    .i_clk_mem  (clk),
    .i_rst      (i_rst),
    .i_addr     (i_addr),
    .i_data_in  (i_data_in),
    .o_data_out (o_data_out),
    .i_read     (i_read),
    .i_write    (i_write),
    .i_width    (i_width),
    .o_irq      (o_irq),
    .o_ovf      (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [15:0] m_cnt [N];
  logic [15:0] m_rel [N];
  logic [7:0]  m_ctl [N];
  int          m_pc  [N];
  int          m_cycle;

  bit          lw_we;
  logic [11:0] lw_a;
  logic [31:0] lw_d;
  logic [1:0]  lw_w;

  function automatic int pmask(input logic [1:0] ps);
    return (ps == 2'd0) ? 0 : ((1 << (2 * int'(ps) + 4)) - 1);
  endfunction

  function automatic bit model_tick();
    return (m_cycle % TD) == (TD - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 16'h0; m_rel[i] = 16'h0; m_ctl[i] = 8'h0; m_pc[i] = 0;
    end
    m_cycle = 0;
  endtask

  function automatic logic [N-1:0] model_ovf();
    logic [N-1:0] ov;
    bit inc;
    ov = '0;
    for (int i = 0; i < N; i++) begin
      inc = 0;
      if (m_ctl[i][7]) begin
        if (i > 0 && m_ctl[i][2]) inc = ov[i-1];
        else inc = model_tick() && ((m_pc[i] & pmask(m_ctl[i][1:0])) == pmask(m_ctl[i][1:0]));
      end
      ov[i] = inc && (m_cnt[i] == 16'hFFFF);
    end
    return ov;
  endfunction

  function automatic logic [N-1:0] model_irq(input logic [N-1:0] ov);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = ov[i] & m_ctl[i][6];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int ai;
    int ch;
    logic [31:0] word;
    ai = int'(a);
    if (ai < BASE || ai >= BASE + 4 * N) return 32'h0;
    ch = (ai - BASE) / 4;
    word = {8'h00, m_ctl[ch], m_cnt[ch]};
    return word >> (8 * (ai % 4));
  endfunction

  task automatic model_step();
    logic [N-1:0] ov;
    bit inc;
    bit tick;
    int ai, ch, off, nb;
    bit wrote_ctl;
    logic [7:0] newctl, byt;
    ov = model_ovf();
    tick = model_tick();
    for (int i = 0; i < N; i++) begin
      if (m_ctl[i][7]) begin
        inc = 0;
        if (i > 0 && m_ctl[i][2]) begin
          inc = ov[i-1];
        end else if (tick) begin
          inc = (m_pc[i] & pmask(m_ctl[i][1:0])) == pmask(m_ctl[i][1:0]);
          m_pc[i] = (m_pc[i] + 1) % 1024;
        end
        if (inc) m_cnt[i] = (m_cnt[i] == 16'hFFFF) ? m_rel[i] : m_cnt[i] + 16'd1;
      end
    end
    ai = int'(lw_a);
    if (lw_we && ai >= BASE && ai < BASE + 4 * N) begin
      ch = (ai - BASE) / 4;
      off = ai % 4;
      nb = (lw_w == 2'd0) ? 1 : (lw_w == 2'd1) ? 2 : 4;
      wrote_ctl = 0;
      newctl = m_ctl[ch];
      for (int b = off; b < off + nb && b < 4; b++) begin
        byt = lw_d[8*(b-off) +: 8];
        case (b)
          0: m_rel[ch][7:0] = byt;
          1: m_rel[ch][15:8] = byt;
          2: begin newctl = byt & ((ch == 0) ? 8'hC3 : 8'hC7); wrote_ctl = 1; end
          default: ;
        endcase
      end
      if (wrote_ctl) begin
        if (newctl[7] && !m_ctl[ch][7]) begin
          m_cnt[ch] = m_rel[ch];
          m_pc[ch] = 0;
        end
        m_ctl[ch] = newctl;
      end
    end
    m_cycle++;
  endtask

  task automatic cyc_drive(input bit we, input logic [11:0] a, input logic [31:0] d,
                           input logic [1:0] w, output logic [EW-1:0] exp);
    logic [N-1:0] ov;
    @(negedge clk);
    i_write = we; i_read = ~we; i_addr = a; i_data_in = d; i_width = w;
    lw_we = we; lw_a = a; lw_d = d; lw_w = w;
    #1;
    ov = model_ovf();
    exp = {ov, model_irq(ov), model_read(a)};
  endtask

  task automatic cyc_end();
    model_step();
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [EW-1:0] exp;
    logic [11:0] addrs [6];
    addrs[0] = 12'h100; addrs[1] = 12'h104; addrs[2] = 12'h108;
    addrs[3] = 12'h10C; addrs[4] = 12'h0FC; addrs[5] = 12'h110;
    i_write = 0; i_read = 0; i_addr = 0; i_data_in = 0; i_width = 0;
    i_rst = 1;
    repeat (3) @(posedge clk);
    #2 i_rst = 0;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      cyc_drive(0, addrs[k], 32'h0, 2'd2, exp);
      n_cmp++;
      if ({o_ovf, o_irq, o_data_out} !== exp || exp !== '0) begin
        n_bad++;
        $display("FAIL reset addr=%h got=%h want=%h", addrs[k], {o_ovf, o_irq, o_data_out}, exp);
      end
      cyc_end();
    end
  endtask

  task automatic run_reads(input string name, input logic [11:0] a, input int cycles);
    logic [EW-1:0] exp;
    for (int k = 0; k < cycles; k++) begin
      cyc_drive(0, a, 32'h0, 2'd2, exp);
      n_cmp++;
      if ({o_ovf, o_irq, o_data_out} !== exp) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", name, k, {o_ovf, o_irq, o_data_out}, exp);
      end
      cyc_end();
    end
  endtask

  task automatic do_write(input string name, input logic [11:0] a, input logic [31:0] d,
                          input logic [1:0] w);
    logic [EW-1:0] exp;
    cyc_drive(1, a, d, w, exp);
    n_cmp++;
    if ({o_ovf, o_irq, o_data_out} !== exp) begin
      n_bad++;
      $display("FAIL %s write a=%h got=%h want=%h", name, a, {o_ovf, o_irq, o_data_out}, exp);
    end
    cyc_end();
  endtask

  task automatic test_ovf_irq();
    do_write("ovf_irq", 12'h100, 32'h00C0_FFFE, 2'd2);
    run_reads("ovf_irq", 12'h100, 12);
  endtask

  task automatic test_cascade();
    do_write("cascade", 12'h100, 32'h0000_0000, 2'd2);
    do_write("cascade", 12'h104, 32'h0084_FFFF, 2'd2);
    do_write("cascade", 12'h100, 32'h0080_FFFF, 2'd2);
    run_reads("cascade", 12'h104, 12);
  endtask

  task automatic test_prescale();
    do_write("prescale", 12'h108, 32'h0081_0000, 2'd2);
    run_reads("prescale", 12'h108, 200);
    do_write("prescale", 12'h10A, 32'h0000_0080, 2'd1);
    run_reads("prescale", 12'h108, 20);
  endtask

  task automatic test_reload_collision();
    logic [EW-1:0] exp;
    bit hit;
    do_write("collide", 12'h100, 32'h0000_FFFF, 2'd2);
    do_write("collide", 12'h100, 32'h0080_FFFF, 2'd2);
    do_write("collide", 12'h100, 32'h0000_0000, 2'd1);
    hit = 0;
    for (int k = 0; k < 12 && !hit; k++) begin
      hit = model_ovf()[0];
      cyc_drive(hit, 12'h100, hit ? 32'h0000_1234 : 32'h0, hit ? 2'd1 : 2'd2, exp);
      n_cmp++;
      if ({o_ovf, o_irq, o_data_out} !== exp) begin
        n_bad++;
        $display("FAIL collide cyc=%0d got=%h want=%h", k, {o_ovf, o_irq, o_data_out}, exp);
      end
      cyc_end();
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL collide_timeout got=no overflow want=overflow within 12 cycles");
    end
    run_reads("collide", 12'h100, 6);
    do_write("collide", 12'h102, 32'h0000_0000, 2'd0);
    do_write("collide", 12'h102, 32'h0000_0080, 2'd0);
    run_reads("collide", 12'h100, 6);
  endtask

  task automatic test_byte_mid_reset();
    logic [EW-1:0] exp;
    do_write("byte3", 12'h103, 32'h0000_0080, 2'd0);
    run_reads("byte3", 12'h100, 8);
    #2 i_rst = 1; i_write = 0; i_addr = 12'h100;
    #1;
    n_cmp++;
    if ({o_ovf, o_irq, o_data_out} !== '0) begin
      n_bad++;
      $display("FAIL midreset got=%h want=0", {o_ovf, o_irq, o_data_out});
    end
    i_addr = 12'h104;
    #1;
    n_cmp++;
    if (o_data_out !== 32'h0) begin
      n_bad++;
      $display("FAIL midreset_ch1 got=%h want=0", o_data_out);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2 i_rst = 0;
    run_reads("post_reset", 12'h100, 8);
    cyc_drive(0, 12'h108, 32'h0, 2'd2, exp);
    n_cmp++;
    if ({o_ovf, o_irq, o_data_out} !== exp) begin
      n_bad++;
      $display("FAIL post_reset_ch2 got=%h want=%h", {o_ovf, o_irq, o_data_out}, exp);
    end
    cyc_end();
  endtask

  task automatic test_random();
    logic [EW-1:0] exp;
    bit we;
    logic [11:0] a;
    logic [31:0] d;
    logic [1:0] w;
    logic [7:0] ctl;
    for (int k = 0; k < 1500; k++) begin
      we = ($urandom_range(0, 9) < 3);
      if (we) begin
        a = 12'(BASE + 4 * $urandom_range(0, N) + $urandom_range(0, 3));
        w = 2'($urandom_range(0, 3));
        ctl = {($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'b000,
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd0};
        d = {8'h00, ctl, 8'hFF, 8'($urandom_range(0, 255))};
      end else begin
        a = 12'($urandom_range(12'h0F8, 12'h11F));
        d = 32'h0;
        w = 2'd2;
      end
      cyc_drive(we, a, d, w, exp);
      n_cmp++;
      if ({o_ovf, o_irq, o_data_out} !== exp) begin
        n_bad++;
        $display("FAIL random cyc=%0d a=%h we=%0d got=%h want=%h", k, a, we,
                 {o_ovf, o_irq, o_data_out}, exp);
      end
      cyc_end();
    end
  endtask

  initial begin
    test_reset();
    test_ovf_irq();
    test_cascade();
    test_prescale();
    test_reload_collision();
    test_byte_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
